// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states,
// opcodes and the select codes driven onto the datapath muxes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    RTEX   = 4'd6,
    RTWB   = 4'd7,
    BEQ    = 4'd8,
    IMMEX  = 4'd9,
    IMMWB  = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_LOGI  = 2'b11;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // andi/ori use zero-extended immediates and the op-decoded logical ALU mode
  function automatic logic is_logic_imm(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI);
  endfunction

  function automatic logic is_known_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || is_logic_imm(op) ||
           (op == OP_J);
  endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// State-to-control decode for the multicycle MIPS controller.
// Pure combinational; write enables are suppressed while rst is high.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t      state,
  input  logic [5:0]  op,
  input  logic        zero,
  input  logic        rst,
  output logic        pc_en,
  output logic        iord,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic        ext_sel,
  output logic        illegal_op,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_src
);

  // Per-state control values; unlisted outputs and unused encodings stay 0
  always_comb begin
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    ext_sel    = 1'b0;
    illegal_op = 1'b0;
    alu_src_b  = SRCB_REG;
    alu_op     = ALU_ADD;
    pc_src     = PC_ALU;
    case (state)
      FETCH: begin
        ir_write  = 1'b1;
        alu_src_b = SRCB_FOUR;
        pc_en     = 1'b1;
      end
      DECODE: begin
        alu_src_b  = SRCB_IMMSH;
        illegal_op = !is_known_op(op);
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      RTEX: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      RTWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      BEQ: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = PC_ALUOUT;
        pc_en     = zero;
      end
      IMMEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        if (is_logic_imm(op)) begin
          alu_op  = ALU_LOGI;
          ext_sel = 1'b1;
        end
      end
      IMMWB: begin
        reg_write = 1'b1;
        ext_sel   = is_logic_imm(op);
      end
      JUMP: begin
        pc_src = PC_JUMP;
        pc_en  = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      pc_en      = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      ir_write   = 1'b0;
      illegal_op = 1'b0;
    end
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS main controller: state register and next-state logic;
// control outputs are produced by mips_ctrl_outdec.
module mips_mc_controller
  import mips_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  op,
  input  logic        zero,
  output logic        pc_en,
  output logic        iord,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic        ext_sel,
  output logic        illegal_op,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_src
);

  state_t state, state_next;

  // State register with synchronous reset back to FETCH
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  // Next-state: op only matters in DECODE and MEMADR
  always_comb begin
    state_next = FETCH;
    case (state)
      FETCH: state_next = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW:             state_next = MEMADR;
          OP_RTYPE:                 state_next = RTEX;
          OP_BEQ:                   state_next = BEQ;
          OP_ADDI, OP_ANDI, OP_ORI: state_next = IMMEX;
          OP_J:                     state_next = JUMP;
          default:                  state_next = FETCH;
        endcase
      end
      MEMADR:  state_next = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_next = MEMWB;
      RTEX:    state_next = RTWB;
      IMMEX:   state_next = IMMWB;
      default: state_next = FETCH;
    endcase
  end

  mips_ctrl_outdec u_outdec (
    .state      (state),
    .op         (op),
    .zero       (zero),
    .rst        (rst),
    .pc_en      (pc_en),
    .iord       (iord),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .ext_sel    (ext_sel),
    .illegal_op (illegal_op),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src)
  );

endmodule
